// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// slave = arbiter view, master = requesters/memory view.
interface mem_port_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [63:0] addr0;
  logic [63:0] addr1;
  logic [63:0] wdata0;
  logic [63:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic [63:0] rdata;
  logic        err;
  logic        busy;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_we;
  logic [63:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output ack0, ack1, rdata, err, busy,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  ack0, ack1, rdata, err, busy,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the 64-bit unified memory data port.
// Define MEMARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module mem_port_arbiter #(
  parameter int MEM_BYTES = 65536
) (
  input  logic                   clock,
  input  logic                   reset_n,
  mem_port_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    ACK
  } state_t;

  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  state_t      state_q, state_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic        bad_q, bad_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;

  logic        pick;
  logic        sel_we;
  logic [63:0] sel_addr;
  logic [63:0] sel_wdata;

`ifdef MEMARB_FIXED_PRIO_EN
  assign pick = ~bus.req0;
`else
  // last_q holds the id granted most recently
  logic last_q, last_d;
  assign pick = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
`endif

  assign sel_we    = pick ? bus.we1    : bus.we0;
  assign sel_addr  = pick ? bus.addr1  : bus.addr0;
  assign sel_wdata = pick ? bus.wdata1 : bus.wdata0;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    we_d        = we_q;
    bad_d       = bad_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
`ifndef MEMARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          win_d = pick;
          we_d  = sel_we;
`ifndef MEMARB_FIXED_PRIO_EN
          last_d = pick;
`endif
          if (sel_addr <= MAX_ADDR) begin
            bad_d       = 1'b0;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_we_d    = sel_we;
            state_d     = ISSUE;
          end else begin
            bad_d   = 1'b1;
            rdata_d = '0;
            state_d = ACK;
          end
        end
      end
      ISSUE: begin
        mem_we_d = 1'b0;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        rdata_d = we_q ? '0 : bus.mem_rdata;
        state_d = ACK;
      end
      ACK: begin
        ack0_d  = ~win_q;
        ack1_d  = win_q;
        err_d   = bad_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      we_q        <= we_d;
      bad_q       <= bad_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_we_q    <= mem_we_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifndef MEMARB_FIXED_PRIO_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`endif

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a byte-addressed memory model.
// Stimulus pushes expected acks; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  typedef struct {
    bit          id;
    logic [63:0] rdata;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   we_cnt = 0;
  exp_t sb[$];

  logic [7:0] mem [0:65535];

  mem_port_arbiter_if ifc ();

  mem_port_arbiter #(.MEM_BYTES(65536)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ifc.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rd64(input logic [63:0] a);
    logic [63:0] v;
    logic [15:0] b;
    b = a[15:0];
    v = '0;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = mem[b + 16'(i)];
    return v;
  endfunction

  task automatic wr64(input logic [63:0] a, input logic [63:0] d);
    logic [15:0] b;
    b = a[15:0];
    for (int i = 0; i < 8; i++) mem[b + 16'(i)] = d[i*8 +: 8];
  endtask

  always @(posedge clk) begin
    ifc.mem_rdata <= rd64(ifc.mem_addr);
    if (ifc.mem_we) begin
      wr64(ifc.mem_addr, ifc.mem_wdata);
      we_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // monitor: every ack must match the oldest expected response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (ifc.ack0 || ifc.ack1)) begin
        chk("ack_onehot", {62'd0, ifc.ack1, ifc.ack0} & 64'h3 ,
            ifc.ack1 ? 64'h2 : 64'h1);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack ack0=%b ack1=%b want none",
                   ifc.ack0, ifc.ack1);
        end else begin
          e = sb.pop_front();
          chk("ack_id", {63'd0, ifc.ack1}, {63'd0, e.id});
          chk("rdata", ifc.rdata, e.rdata);
          chk("err", {63'd0, ifc.err}, {63'd0, e.err});
        end
      end
    end
  end

  task automatic set_req(input bit id, input bit v, input bit we,
                         input logic [63:0] a, input logic [63:0] d);
    if (id) begin
      ifc.req1 = v; ifc.we1 = we; ifc.addr1 = a; ifc.wdata1 = d;
    end else begin
      ifc.req0 = v; ifc.we0 = we; ifc.addr0 = a; ifc.wdata0 = d;
    end
  endtask

  task automatic txn(input string name, input bit id, input bit we,
                     input logic [63:0] a, input logic [63:0] d,
                     input logic [63:0] exp_rd, input bit exp_err,
                     input int exp_lat);
    int  n;
    bit  seen;
    exp_t e;
    @(negedge clk);
    e.id = id; e.rdata = exp_rd; e.err = exp_err;
    sb.push_back(e);
    set_req(id, 1'b1, we, a, d);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if ((id && ifc.ack1) || (!id && ifc.ack0)) seen = 1;
    end
    set_req(id, 1'b0, 1'b0, 64'd0, 64'd0);
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout ack never seen want ack%0d", name, id);
    end else begin
      chk({name, "_lat"}, 64'(n - 1), 64'(exp_lat));
    end
  endtask

  initial begin
    int w0;
    int n;
    int acks;
    int last_n;
    ifc.req0 = 0; ifc.req1 = 0; ifc.we0 = 0; ifc.we1 = 0;
    ifc.addr0 = 0; ifc.addr1 = 0; ifc.wdata0 = 0; ifc.wdata1 = 0;
    ifc.mem_rdata = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    wr64(64'h10, 64'h1122334455667788);
    wr64(64'hFFF8, 64'hA5A5_0102_0304_5A5A);

    repeat (3) @(negedge clk);
    chk("rst_ack0", {63'd0, ifc.ack0}, 64'd0);
    chk("rst_ack1", {63'd0, ifc.ack1}, 64'd0);
    chk("rst_err", {63'd0, ifc.err}, 64'd0);
    chk("rst_busy", {63'd0, ifc.busy}, 64'd0);
    chk("rst_mem_we", {63'd0, ifc.mem_we}, 64'd0);
    chk("rst_rdata", ifc.rdata, 64'd0);
    chk("rst_mem_addr", ifc.mem_addr, 64'd0);
    chk("rst_mem_wdata", ifc.mem_wdata, 64'd0);
    rst_n = 1'b1;

    txn("rd0", 0, 0, 64'h10, 64'd0, 64'h1122334455667788, 0, 3);

    w0 = we_cnt;
    txn("wr1", 1, 1, 64'h100, 64'hDEADBEEFCAFEF00D, 64'd0, 0, 3);
    chk("wr1_we_pulses", 64'(we_cnt - w0), 64'd1);
    chk("wr1_mem", rd64(64'h100), 64'hDEADBEEFCAFEF00D);
    txn("rd1", 1, 0, 64'h100, 64'd0, 64'hDEADBEEFCAFEF00D, 0, 3);

    // both requesters held; four back-to-back grants
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
`ifdef MEMARB_FIXED_PRIO_EN
      e.id = 0;
`else
      e.id = (k % 2 == 1);
`endif
      e.rdata = e.id ? 64'hDEADBEEFCAFEF00D : 64'h1122334455667788;
      e.err = 0;
      sb.push_back(e);
    end
    set_req(0, 1'b1, 1'b0, 64'h10, 64'd0);
    set_req(1, 1'b1, 1'b0, 64'h100, 64'd0);
    n = 0; acks = 0; last_n = 0;
    while (acks < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (ifc.ack0 || ifc.ack1) begin
        acks++;
        if (acks > 1) chk("cont_gap", 64'(n - last_n), 64'd4);
        last_n = n;
      end
    end
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_req(1, 1'b0, 1'b0, 64'd0, 64'd0);
    chk("cont_acks", 64'(acks), 64'd4);

    txn("edge_ok", 0, 0, 64'hFFF8, 64'd0, 64'hA5A5_0102_0304_5A5A, 0, 3);
    w0 = we_cnt;
    txn("edge_bad_wr", 0, 1, 64'hFFF9, 64'h5555, 64'd0, 1, 1);
    chk("edge_bad_no_we", 64'(we_cnt - w0), 64'd0);
    chk("edge_bad_mem", rd64(64'hFFF8), 64'hA5A5_0102_0304_5A5A);
    txn("wrap_bad", 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 1, 1);

    // reset while the write is in ISSUE
    @(negedge clk);
    w0 = we_cnt;
    set_req(0, 1'b1, 1'b1, 64'h200, 64'h0BAD_0BAD_0BAD_0BAD);
    @(negedge clk);
    chk("mid_in_issue_we", {63'd0, ifc.mem_we}, 64'd1);
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk("mid_we_async", {63'd0, ifc.mem_we}, 64'd0);
    chk("mid_busy", {63'd0, ifc.busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_mem", rd64(64'h200), 64'd0);
    chk("mid_no_we", 64'(we_cnt - w0), 64'd0);
    chk("mid_busy_after", {63'd0, ifc.busy}, 64'd0);
    txn("after_rst", 0, 0, 64'h10, 64'd0, 64'h1122334455667788, 0, 3);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the data port of the byte-addressed 64-bit unified memory. It shares the single `mem_addr`/`val`/`R_W` port between requester 0 (CPU memory stage) and requester 1 (loader/debug master). It serializes their 8-byte read and write transactions and range-checks addresses. It sits between the requesters and the memory; the instruction-fetch path (`pc`/`pc_out`) is untouched.

## Interface
Parameters:
- `MEM_BYTES`, default 65536: memory size in bytes; legal transaction addresses are 0 .. MEM_BYTES-8.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1 each: transaction request; held with payload until the matching ack.
- `we0`, `we1` in 1 each: 1 = write, 0 = read.
- `addr0`, `addr1` in 64 each: byte address, little-endian 8-byte access.
- `wdata0`, `wdata1` in 64 each: write data.
- `ack0`, `ack1` out 1 each: one-cycle completion pulse.
- `rdata` out 64: read data, valid while any ack is high.
- `err` out 1: range error, valid while any ack is high.
- `busy` out 1: high in any state other than IDLE.
- `mem_addr` out 64: to memory `mem_addr`.
- `mem_wdata` out 64: to memory `val`.
- `mem_we` out 1: to memory `R_W`.
- `mem_rdata` in 64: from memory `m_out`.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, ACK. All outputs are registered.
- Reset values: state IDLE; `ack0`/`ack1`/`err`/`mem_we`/`busy` 0; `rdata`/`mem_addr`/`mem_wdata` 0; round-robin pointer favours requester 0.
- **IDLE:**
  - If no req, stay.
  - Otherwise select a winner.
    - Round-robin: when both request, grant the one not granted last. When only one requests, grant it.
    - Update the pointer on each grant.
  - Latch the winner id, we, addr, and wdata.
  - Legal address (`addr <= MEM_BYTES-8`, full 64-bit unsigned compare, so no wrap): drive `mem_addr`, `mem_wdata`, and `mem_we = we`, then go to ISSUE.
  - Illegal address: go to ACK with `err=1` and `rdata=0`. No memory access occurs and `mem_we` stays 0.
- **ISSUE:** The memory performs the access on the edge ending this cycle. Next state is CAPTURE, and `mem_we` is cleared on that edge.
- **CAPTURE:** `mem_rdata` is valid. Register it into `rdata`; for writes, register 0. Next state is ACK.
- **ACK:** Raise `ackN` of the winner only, for exactly one cycle. `err` is valid. Next state is IDLE, and ack/err clear on that edge. `rdata` holds its value until the next capture.
- Requesters drop or renew `req` in the cycle after ack. A req still high in IDLE is a new transaction.
- A request is never granted while the FSM is not in IDLE. Request changes outside IDLE are ignored.
- `mem_addr` holds its last value outside ISSUE. Memory read-side side effects are harmless.
- Reset mid-operation: all state clears immediately and `mem_we` drops asynchronously.
  - If reset is asserted before the ISSUE edge, no write occurs.
  - The in-flight requester receives no ack and must reissue.

## Timing
- Legal transaction: req sampled at edge E0. Memory access at E1. Data captured at E2. `ack` is high in the cycle E3..E4.
- Read latency is 3 cycles from the sampling edge to ack.
- Illegal transaction: ack is high in the cycle after the sampling edge (E1..E2).
- Maximum throughput is one legal transaction per 4 cycles.
- `mem_we` is high for exactly one cycle (ISSUE) per legal write.
- Both requests arriving in the same cycle are resolved by arbitration. The loser waits and is granted in the next IDLE in which its req is still high.

## Configuration
- `MEMARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins simultaneous requests, and the round-robin pointer is removed.
  - Undefined (default): round-robin as above, so no requester starves.

## Test plan
- Reset: `reset_n=0` -> all outputs 0, `busy=0`. Release reset, then `req0` reading addr 0x10 from a memory preloaded with 0x1122334455667788 -> `ack0` exactly 3 cycles after sampling, `rdata=0x1122334455667788`, `err=0`.
- Write then read: `req1` writes 0xDEADBEEFCAFEF00D at 0x100, then reads 0x100 -> one `mem_we` pulse, and the read returns 0xDEADBEEFCAFEF00D on `ack1`.
- Contention:
  - `req0` and `req1` are held continuously. Default build: acks alternate 0,1,0,1.
  - Under `MEMARB_FIXED_PRIO_EN`: only `ack0` pulses while `req0` is held.
- Range:
  - addr 0xFFF8 with `MEM_BYTES`=65536 -> normal access.
  - addr 0xFFF9 -> `err=1`, `rdata=0`, no `mem_we`, ack 1 cycle after sampling.
  - addr 0xFFFFFFFFFFFFFFFC -> `err=1`.
- Reset mid-write: assert `reset_n=0` during ISSUE, before the edge -> memory at target unchanged, no ack, FSM IDLE after release.
